wave_addr_gen: RTL and testbench

//  Phase-accumulator address generator for the triangle/duty waveform lookup stage.
//  Per sample tick it advances an ACC_W-bit phase and emits the top ADDR_W bits as the

---
 rtl/wave_gen_pkg.sv | 22 ++
 rtl/wave_addr_gen_phase_acc.sv | 42 ++++
 rtl/wave_addr_gen.sv | 166 ++++++++++++++++
 tb/tb_wave_addr_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
// Shared constants and types for the waveform address generator and the
// downstream triangle/duty lookup stage.
package wave_gen_pkg;

  localparam int ADDR_W   = 10;
  localparam int SEL_W    = 4;
  localparam int MEM_SIZE = 1 << ADDR_W;

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(10);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } wag_state_t;

  // Out-of-range duty selects saturate at 100%.
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel);
    return (sel > SEL_MAX) ? SEL_MAX : sel;
  endfunction

endpackage

// File: rtl/wave_addr_gen_phase_acc.sv
// Phase accumulator: ACC_W-bit register advanced by the tuning word on each
// enabled cycle. Exposes the post-add address bits and carry combinationally
// so the caller can form the sample in the same cycle as the step.
module phase_acc #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [ACC_W-1:0]  i_inc,
  output logic [ADDR_W-1:0] o_addr_next,
  output logic              o_carry
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;

  assign {o_carry, sum} = {1'b0, acc_q} + {1'b0, i_inc};
  assign o_addr_next    = sum[ACC_W-1 -: ADDR_W];

  // Clear has priority over stepping so a restart always begins at phase 0.
  always_comb begin
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_en) begin
      acc_d = sum;
    end
  end

  // Phase register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/wave_addr_gen.sv
// Waveform lookup address generator: run/stop FSM around a phase accumulator,
// glitch-free config updates at period boundaries, and a one-deep output
// register with valid/ready handshake and a sticky overrun flag.
module wave_addr_gen
  import wave_gen_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [ACC_W-1:0]  i_cfg_tuning,
  input  logic [SEL_W-1:0]  i_cfg_sel,
  input  logic              i_tick,
  output logic [ADDR_W-1:0] o_addr,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_wrap,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_overrun
);

  wag_state_t state_q, state_d;

  logic [ACC_W-1:0]  tuning_act_q, tuning_act_d;
  logic [SEL_W-1:0]  sel_act_q, sel_act_d;
  logic [ACC_W-1:0]  tuning_sh_q, tuning_sh_d;
  logic [SEL_W-1:0]  sel_sh_q, sel_sh_d;
  logic              pend_q, pend_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              wrap_q, wrap_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  logic [ADDR_W-1:0] addr_next;
  logic              carry;
  logic              start_only, busy, tick_act, stop_drop, emit, load, drop;
  logic              acc_clr, cfg_fire, apply_pend;

  assign busy        = (state_q != IDLE);
  assign start_only  = i_start && !i_stop;
  assign tick_act    = i_tick && busy;
  // The carrying tick that ends a pending stop produces no sample.
  assign stop_drop   = tick_act && (state_q == STOP_PEND) && carry && !start_only;
  assign emit        = tick_act && !stop_drop;
  assign load        = emit && (!valid_q || i_ready);
  assign drop        = emit && valid_q && !i_ready;
  assign acc_clr     = ((state_q == IDLE) && start_only) || stop_drop;
  assign cfg_fire    = i_cfg_valid && o_cfg_ready;
  assign apply_pend  = pend_q && (((state_q == IDLE) && start_only) || (tick_act && carry));

  phase_acc #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_phase_acc (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (acc_clr),
    .i_en        (tick_act),
    .i_inc       (tuning_act_q),
    .o_addr_next (addr_next),
    .o_carry     (carry)
  );

  // Run/stop next-state logic; a zero tuning word can never wrap, so stop is immediate.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_only) state_d = RUN;
      end
      RUN: begin
        if (i_stop) state_d = (tuning_act_q == '0) ? IDLE : STOP_PEND;
      end
      STOP_PEND: begin
        if (start_only)     state_d = RUN;
        else if (stop_drop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Config capture: direct in IDLE, otherwise shadowed until the next period boundary.
  always_comb begin
    tuning_act_d = tuning_act_q;
    sel_act_d    = sel_act_q;
    tuning_sh_d  = tuning_sh_q;
    sel_sh_d     = sel_sh_q;
    pend_d       = pend_q;
    if (cfg_fire && (state_q == IDLE)) begin
      tuning_act_d = i_cfg_tuning;
      sel_act_d    = clamp_sel(i_cfg_sel);
    end else if (cfg_fire) begin
      tuning_sh_d  = i_cfg_tuning;
      sel_sh_d     = clamp_sel(i_cfg_sel);
      pend_d       = 1'b1;
    end else if (apply_pend) begin
      tuning_act_d = tuning_sh_q;
      sel_act_d    = sel_sh_q;
      pend_d       = 1'b0;
    end
  end

  // Output register: load on accepted slot, hold under backpressure, clear after handshake.
  always_comb begin
    addr_d    = addr_q;
    sel_d     = sel_q;
    wrap_d    = wrap_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      addr_d  = addr_next;
      sel_d   = sel_act_q;
      wrap_d  = carry;
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (i_start)   overrun_d = 1'b0;
    else if (drop) overrun_d = 1'b1;
  end

  // State, config and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      tuning_act_q <= '0;
      sel_act_q    <= '0;
      tuning_sh_q  <= '0;
      sel_sh_q     <= '0;
      pend_q       <= 1'b0;
      addr_q       <= '0;
      sel_q        <= '0;
      wrap_q       <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tuning_act_q <= tuning_act_d;
      sel_act_q    <= sel_act_d;
      tuning_sh_q  <= tuning_sh_d;
      sel_sh_q     <= sel_sh_d;
      pend_q       <= pend_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      wrap_q       <= wrap_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_cfg_ready = !pend_q;
  assign o_addr      = addr_q;
  assign o_sel       = sel_q;
  assign o_wrap      = wrap_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_wave_addr_gen.sv
// Bench for wave_addr_gen: table of single-step configurations, then
// multi-cycle sequences (full period, deferred config, overrun, stop, reset).
module tb_wave_addr_gen;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_STOP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_stop = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic        o_cfg_ready;
  logic [31:0] i_cfg_tuning = '0;
  logic [3:0]  i_cfg_sel = '0;
  logic        i_tick = 1'b0;
  logic [9:0]  o_addr;
  logic [3:0]  o_sel;
  logic        o_wrap, o_valid, o_busy, o_overrun;
  logic        i_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [9:0] addr;
    logic [3:0] sel;
    logic       wrap;
  } smp_t;

  typedef struct {
    logic [31:0] tun;
    logic [3:0]  sel;
    logic [9:0]  exp_addr;
    logic [3:0]  exp_sel;
    logic        exp_wrap;
    logic        exp_busy_after_stop;
  } vec_t;

  smp_t q[$];

  // Reference model of the generator as seen from the ports.
  logic [31:0] m_acc, m_tun, m_sh_tun;
  logic [3:0]  m_sel, m_sh_sel;
  logic        m_pend;
  int          m_state;

  wave_addr_gen #(.ACC_W(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_cfg_valid  (i_cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .i_cfg_tuning (i_cfg_tuning),
    .i_cfg_sel    (i_cfg_sel),
    .i_tick       (i_tick),
    .o_addr       (o_addr),
    .o_sel        (o_sel),
    .o_wrap       (o_wrap),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // Scoreboard: every handshake pops the oldest expected sample.
  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      smp_t got, exp;
      got = '{addr: o_addr, sel: o_sel, wrap: o_wrap};
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sample_unexpected got addr=%0d sel=%0d wrap=%0d, none required", o_addr, o_sel, o_wrap);
      end else begin
        exp = q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL sample got addr=%0d sel=%0d wrap=%0d, required addr=%0d sel=%0d wrap=%0d",
                   got.addr, got.sel, got.wrap, exp.addr, exp.sel, exp.wrap);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] clampm(input logic [3:0] s);
    return (s > 4'd10) ? 4'd10 : s;
  endfunction

  task automatic model_reset();
    m_acc = '0; m_tun = '0; m_sel = '0; m_sh_tun = '0; m_sh_sel = '0;
    m_pend = 1'b0; m_state = S_IDLE;
    q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    i_start = 0; i_stop = 0; i_tick = 0; i_cfg_valid = 0; i_ready = 1;
    #4;
    model_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(input logic [31:0] tun, input logic [3:0] sel);
    bit done = 0;
    @(posedge clk); #1;
    i_cfg_valid = 1; i_cfg_tuning = tun; i_cfg_sel = sel;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (o_cfg_ready) done = 1;
      @(posedge clk); #1;
    end
    i_cfg_valid = 0;
    if (!done) check("cfg_accept_timeout", 0, 1);
    else if (m_state == S_IDLE) begin
      m_tun = tun; m_sel = clampm(sel);
    end else begin
      m_sh_tun = tun; m_sh_sel = clampm(sel); m_pend = 1;
    end
  endtask

  task automatic pulse(input bit st, input bit sp);
    @(posedge clk); #1;
    i_start = st; i_stop = sp;
    if (sp) begin
      if (m_state == S_RUN) m_state = (m_tun == 0) ? S_IDLE : S_STOP;
    end else if (st) begin
      if (m_state == S_IDLE) begin
        m_state = S_RUN; m_acc = '0;
        if (m_pend) begin m_tun = m_sh_tun; m_sel = m_sh_sel; m_pend = 0; end
      end else if (m_state == S_STOP) begin
        m_state = S_RUN;
      end
    end
    @(posedge clk); #1;
    i_start = 0; i_stop = 0;
  endtask

  // One tick; push=0 lets the caller supply the expected sample itself,
  // drop=1 means the caller holds an unaccepted sample so this one is lost.
  task automatic do_tick(input bit push, input bit drop);
    logic [32:0] s;
    @(posedge clk); #1;
    i_tick = 1;
    if (m_state != S_IDLE) begin
      s = {1'b0, m_acc} + {1'b0, m_tun};
      if (m_state == S_STOP && s[32]) begin
        m_state = S_IDLE; m_acc = '0;
      end else begin
        m_acc = s[31:0];
        if (push && !drop) q.push_back('{addr: s[31:22], sel: m_sel, wrap: s[32]});
      end
      if (s[32] && m_pend) begin m_tun = m_sh_tun; m_sel = m_sh_sel; m_pend = 0; end
    end
    @(posedge clk); #1;
    i_tick = 0;
  endtask

  initial begin
    vec_t vecs[6];
    logic [9:0] base;
    int n;

    vecs[0] = '{32'h0040_0000, 4'd5,  10'd1,   4'd5,  1'b0, 1'b1};
    vecs[1] = '{32'h0080_0000, 4'd12, 10'd2,   4'd10, 1'b0, 1'b1};
    vecs[2] = '{32'hFFC0_0000, 4'd10, 10'h3FF, 4'd10, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0000, 4'd3,  10'd0,   4'd3,  1'b0, 1'b0};
    vecs[4] = '{32'h0000_0001, 4'd15, 10'd0,   4'd10, 1'b0, 1'b1};
    vecs[5] = '{32'h8000_0000, 4'd0,  10'd512, 4'd0,  1'b0, 1'b1};

    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_valid", o_valid, 0);
    check("reset_busy", o_busy, 0);
    check("reset_cfg_ready", o_cfg_ready, 1);
    check("reset_overrun", o_overrun, 0);

    // Table: one step from phase 0 per configuration, then stop.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      do_cfg(vecs[i].tun, vecs[i].sel);
      pulse(1, 0);
      check("tbl_busy_run", o_busy, 1);
      q.push_back('{addr: vecs[i].exp_addr, sel: vecs[i].exp_sel, wrap: vecs[i].exp_wrap});
      do_tick(0, 0);
      check("tbl_latency_valid", o_valid, 1);
      pulse(0, 1);
      check("tbl_busy_after_stop", o_busy, vecs[i].exp_busy_after_stop);
    end

    // Step 1, sel 5: first samples, then a full period up to the wrap.
    do_reset();
    do_cfg(32'h0040_0000, 4'd5);
    pulse(1, 0);
    for (int i = 1; i <= 4; i++) begin
      do_tick(1, 0);
      check("first_valid_latency", o_valid, 1);
      check("first_addr", o_addr, i);
    end
    for (int i = 5; i <= 1024; i++) do_tick(1, 0);
    check("period_wrap_addr", o_addr, 0);
    check("period_wrap_flag", o_wrap, 1);

    // Deferred config offered mid-period.
    for (int i = 0; i < 100; i++) do_tick(1, 0);
    check("cfg_at_addr100", o_addr, 100);
    do_cfg(32'h0080_0000, 4'd12);
    check("cfg_ready_low", o_cfg_ready, 0);
    for (int i = 0; i < 923; i++) do_tick(1, 0);
    check("cfg_ready_low_before_wrap", o_cfg_ready, 0);
    do_tick(1, 0);
    check("cfg_wrap_sel_old", o_sel, 5);
    check("cfg_ready_back", o_cfg_ready, 1);
    for (int i = 0; i < 3; i++) do_tick(1, 0);
    check("cfg_new_step", o_addr, 6);
    check("cfg_new_sel", o_sel, 10);

    // Backpressure across two ticks.
    @(posedge clk); #1;
    base = m_acc[31:22];
    i_ready = 0;
    do_tick(1, 0);
    do_tick(1, 1);
    check("ovr_hold_addr", o_addr, 10'(base + 10'd2));
    check("ovr_flag", o_overrun, 1);
    i_ready = 1;
    @(posedge clk); #1;
    do_tick(1, 0);
    check("ovr_three_steps", o_addr, 10'(base + 10'd6));
    check("ovr_sticky", o_overrun, 1);
    pulse(1, 0);
    check("ovr_cleared_by_start", o_overrun, 0);
    check("ovr_still_busy", o_busy, 1);

    // Stop at address 500: finish the period, drop the wrap sample.
    n = 0;
    while (m_acc[31:22] != 10'd500 && n < 2000) begin do_tick(1, 0); n++; end
    check("stop_reach_500", m_acc[31:22] == 10'd500, 1);
    pulse(0, 1);
    check("stop_busy_pending", o_busy, 1);
    n = 0;
    while (m_state != S_IDLE && n < 2000) begin do_tick(1, 0); n++; end
    check("stop_model_idle", m_state, S_IDLE);
    check("stop_last_addr", o_addr, 1022);
    check("stop_busy_done", o_busy, 0);
    check("stop_no_valid", o_valid, 0);
    do_tick(1, 0);
    pulse(1, 1);
    check("start_stop_same_cycle_idle", o_busy, 0);

    // Asynchronous reset while a sample is held and overrun is set.
    pulse(1, 0);
    i_ready = 0;
    do_tick(1, 0);
    do_tick(1, 1);
    check("pre_reset_overrun", o_overrun, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_addr", o_addr, 0);
    check("rst_sel", o_sel, 0);
    check("rst_busy", o_busy, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_cfg_ready", o_cfg_ready, 1);
    model_reset();
    i_ready = 1;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    do_tick(1, 0);
    check("post_rst_idle", o_busy, 0);
    check("post_rst_no_valid", o_valid, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
